// File: rtl/rom_burst_reader.sv
// rom_burst_reader: parametrised read-only coefficient table with a burst
// request/response handshake. One request returns req_len+1 registered beats
// using linear or wrap-around addressing, with back-pressure on the beat side
// and an error flag for addresses beyond the table.
module rom_burst_reader #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_wrap,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Table bounds held one bit wider than an address so DEPTH == 2^ADDR_W fits.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    beats_left;
    logic                wrap_q;

    logic [ADDR_W-1:0]   load_addr;
    logic                load_err;
    logic [DATA_W-1:0]   load_data;
    logic                beat_hs;
    logic                req_hs;

    // Table contents: entry i holds 2*i, truncated to the entry width.
    function automatic logic [DATA_W-1:0] table_entry(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] doubled;
        doubled = {addr, 1'b0};
        return DATA_W'(doubled);
    endfunction

    // Successor address: wrap mode folds back to 0 at (or past) the last entry.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic              wrap);
        logic [ADDR_W-1:0] result;
        if (wrap && ({1'b0, addr} >= LAST_L)) begin
            result = '0;
        end else begin
            result = addr + ADDR_W'(1);
        end
        return result;
    endfunction

    // Accept requests only when idle and not held in reset.
    assign req_ready = (state == IDLE) && rst_n;
    assign req_hs    = req_valid && req_ready;
    assign beat_hs   = rd_valid && rd_ready;

    // Address of the beat about to be loaded and its table lookup.
    always_comb begin
        load_addr = req_addr;
        if (state == BURST) begin
            load_addr = next_addr(addr_q, wrap_q);
        end
        load_err  = ({1'b0, load_addr} >= DEPTH_L);
        load_data = load_err ? '0 : table_entry(load_addr);
    end

    // Burst control FSM with the registered beat outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            beats_left <= '0;
            wrap_q     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        state      <= BURST;
                        addr_q     <= req_addr;
                        beats_left <= req_len;
                        wrap_q     <= req_wrap;
                        rd_valid   <= 1'b1;
                        rd_data    <= load_data;
                        rd_err     <= load_err;
                        rd_last    <= (req_len == '0);
                    end
                end
                BURST: begin
                    if (beat_hs) begin
                        if (beats_left != '0) begin
                            addr_q     <= load_addr;
                            beats_left <= beats_left - LEN_W'(1);
                            rd_data    <= load_data;
                            rd_err     <= load_err;
                            rd_last    <= (beats_left == LEN_W'(1));
                        end else begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed testbench for rom_burst_reader with the default parameters
// (4-bit entries, 8 entries, 8-bit addresses, 4-bit length field).
module tb_rom_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic       req_wrap;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic       rd_last;
    logic       rd_err;

    int n_checks;
    int n_fail;

    rom_burst_reader #(
        .DATA_W(4),
        .DEPTH (8),
        .ADDR_W(8),
        .LEN_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .req_wrap (req_wrap),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_err   (rd_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (rd_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_rd_valid cyc%0d: got %b expected 0", i, rd_valid);
            end
            n_checks++;
            if (rd_data !== 4'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_rd_data cyc%0d: got %0d expected 0", i, rd_data);
            end
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_req_ready cyc%0d: got %b expected 0", i, req_ready);
            end
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_req_ready: got %b expected 1", req_ready);
        end
        step();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_beat: got rd_valid %b expected 0", rd_valid);
        end
    endtask

    task automatic test_single();
        req_valid = 1'b1;
        req_addr  = 8'd3;
        req_len   = 4'd0;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, rd_last, rd_err} !== {1'b1, 4'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_beat: got v=%b d=%0d l=%b e=%b expected v=1 d=6 l=1 e=0",
                     rd_valid, rd_data, rd_last, rd_err);
        end
        step();
        n_checks++;
        if ({rd_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL single_after: got rd_valid=%b req_ready=%b expected 0 1",
                     rd_valid, req_ready);
        end
    endtask

    task automatic test_linear();
        logic [3:0] exp_data [4];
        logic       exp_err  [4];
        exp_data = '{4'd10, 4'd12, 4'd14, 4'd0};
        exp_err  = '{1'b0, 1'b0, 1'b0, 1'b1};
        req_valid = 1'b1;
        req_addr  = 8'd5;
        req_len   = 4'd3;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rd_valid, rd_data, rd_last, rd_err} !==
                {1'b1, exp_data[i], (i == 3), exp_err[i]}) begin
                n_fail++;
                $display("[TB] FAIL linear_beat%0d: got v=%b d=%0d l=%b e=%b expected v=1 d=%0d l=%b e=%b",
                         i, rd_valid, rd_data, rd_last, rd_err, exp_data[i], (i == 3), exp_err[i]);
            end
            step();
        end
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL linear_end: got rd_valid %b expected 0", rd_valid);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_data [4];
        exp_data = '{4'd12, 4'd14, 4'd0, 4'd2};
        req_valid = 1'b1;
        req_addr  = 8'd6;
        req_len   = 4'd3;
        req_wrap  = 1'b1;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rd_valid, rd_data, rd_last, rd_err} !==
                {1'b1, exp_data[i], (i == 3), 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL wrap_beat%0d: got v=%b d=%0d l=%b e=%b expected v=1 d=%0d l=%b e=0",
                         i, rd_valid, rd_data, rd_last, rd_err, exp_data[i], (i == 3));
            end
            step();
        end
        n_checks++;
        if ({rd_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL wrap_end: got rd_valid=%b req_ready=%b expected 0 1",
                     rd_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1;
        req_addr  = 8'd0;
        req_len   = 4'd2;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, rd_last} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL bp_beat0: got v=%b d=%0d l=%b expected v=1 d=0 l=0",
                     rd_valid, rd_data, rd_last);
        end
        step();
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({rd_valid, rd_data, rd_last, rd_err} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL bp_stall%0d: got v=%b d=%0d l=%b e=%b expected v=1 d=2 l=0 e=0",
                         i, rd_valid, rd_data, rd_last, rd_err);
            end
            if (i < 2) step();
        end
        rd_ready = 1'b1;
        step();
        n_checks++;
        if ({rd_valid, rd_data, rd_last} !== {1'b1, 4'd4, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL bp_beat2: got v=%b d=%0d l=%b expected v=1 d=4 l=1",
                     rd_valid, rd_data, rd_last);
        end
        step();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_end: got rd_valid %b expected 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 1'b1;
        req_addr  = 8'd0;
        req_len   = 4'd7;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, req_ready} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mid_beat0: got v=%b d=%0d req_ready=%b expected v=1 d=0 req_ready=0",
                     rd_valid, rd_data, req_ready);
        end
        step();
        n_checks++;
        if ({rd_valid, rd_data, req_ready} !== {1'b1, 4'd2, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mid_beat1: got v=%b d=%0d req_ready=%b expected v=1 d=2 req_ready=0",
                     rd_valid, rd_data, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = 8'd5;
        req_len   = 4'd0;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, rd_last} !== {1'b1, 4'd4, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mid_beat2: got v=%b d=%0d l=%b expected v=1 d=4 l=0",
                     rd_valid, rd_data, rd_last);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({rd_valid, req_ready, rd_data} !== {1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got v=%b req_ready=%b d=%0d expected 0 0 0",
                     rd_valid, req_ready, rd_data);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({rd_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL mid_after_reset: got rd_valid=%b req_ready=%b expected 0 1",
                     rd_valid, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = 8'd1;
        req_len   = 4'd0;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rd_valid, rd_data, rd_last, rd_err} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mid_new_req: got v=%b d=%0d l=%b e=%b expected v=1 d=2 l=1 e=0",
                     rd_valid, rd_data, rd_last, rd_err);
        end
        step();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_new_end: got rd_valid %b expected 0", rd_valid);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 8'd3;
        req_len   = 4'd0;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        test_reset();
        test_single();
        test_linear();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Parametrised read-only lookup table with a request/response handshake. A single request returns a burst of one or more consecutive entries, with either linear or wrap-around addressing. Output back-pressure is supported. The block is the generalised successor of the team's fixed 8×4 ROM: the same default contents, but configurable width and depth, registered beats with valid/ready, and out-of-range error reporting. It sits between a control FSM issuing table lookups and the datapath consuming the coefficients.

## Interface
- DATA_W, 4: entry width in bits.
- DEPTH, 8: number of entries; must be at least 2 and at most 2^ADDR_W.
- ADDR_W, 8: address width.
- LEN_W, 4: burst length field width; a burst is req_len+1 beats, so 1..2^LEN_W beats.

Entry contents are fixed at elaboration: mem[i] = (2*i) mod 2^DATA_W for i in 0..DEPTH-1. With the defaults this gives 0,2,4,...,14.

- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- req_valid, input, 1: burst request present.
- req_ready, output, 1: block can accept a request.
- req_addr, input, ADDR_W: start address.
- req_len, input, LEN_W: number of beats minus 1.
- req_wrap, input, 1: 1 = wrap addressing, 0 = linear addressing.
- rd_valid, output, 1: rd_data/rd_last/rd_err are valid.
- rd_ready, input, 1: consumer accepts the current beat.
- rd_data, output, DATA_W: entry value; 0 when rd_err=1.
- rd_last, output, 1: final beat of the burst.
- rd_err, output, 1: this beat's address was >= DEPTH.

## Operation
- States: IDLE and BURST.
- req_ready = (state==IDLE) && rst_n. It is combinational and is 0 in any cycle where rst_n is low.
- IDLE to BURST on the request handshake (req_valid && req_ready).
  - Latch addr_q=req_addr, beats_left=req_len, wrap_q=req_wrap.
  - Load the output register with beat 0.
- In BURST, a beat handshake (rd_valid && rd_ready) with beats_left>0:
  - Load the next beat.
  - Decrement beats_left.
  - Advance addr_q.
- A beat handshake with rd_last=1 moves BURST to IDLE and clears rd_valid.
- When rd_valid && !rd_ready: rd_data, rd_last and rd_err hold stable, and addr_q and beats_left hold.
- Address advance in linear mode: addr_q+1 modulo 2^ADDR_W. Addresses >= DEPTH produce rd_err=1 and rd_data=0, and the burst continues.
- Address advance in wrap mode: next = (addr_q >= DEPTH-1) ? 0 : addr_q+1. Only a start address >= DEPTH can give rd_err=1 in wrap mode; that beat errors and the next address is 0.
- rd_last is 1 exactly when the loaded beat has beats_left==0.
- req_valid, req_addr, req_len and req_wrap are ignored outside the handshake cycle. The request fields may change freely during a burst.

## Timing
- Reset, sampled at a rising edge with rst_n=0: state=IDLE, rd_valid=0, rd_data=0, rd_last=0, rd_err=0, and internal counters 0.
- Reset mid-burst aborts the burst at that edge. No further beats are produced.
- Latency: request handshake at edge N gives rd_valid=1 with beat 0 after edge N.
- Throughput: with rd_ready held at 1, beats are back-to-back, one per cycle, with no bubbles. A burst of L beats occupies L cycles of rd_valid.
- Turnaround: the final-beat handshake at edge M gives req_ready=1 in the cycle after edge M. A new request accepted at edge M+1 produces beat 0 after edge M+1. There is therefore exactly one idle output cycle between bursts.
- rd_valid never deasserts before its beat is accepted, except by reset.

## Test plan
All scenarios use the defaults DATA_W=4, DEPTH=8, ADDR_W=8, LEN_W=4.

1. Reset:
   - Stimulus: hold rst_n=0 for 2 cycles with req_valid=1.
   - Required: rd_valid=0, rd_data=0, req_ready=0 throughout.
   - Required: req_ready=1 in the first cycle after rst_n=1, and no beat is generated from the request held during reset.
2. Single read:
   - Stimulus: req_addr=3, req_len=0, req_wrap=0, rd_ready=1.
   - Required: one cycle later rd_valid=1, rd_data=6, rd_last=1, rd_err=0.
   - Required: the next cycle rd_valid=0 and req_ready=1.
3. Linear burst past the end:
   - Stimulus: req_addr=5, req_len=3, req_wrap=0, rd_ready=1.
   - Required: rd_data 10,12,14,0 on consecutive cycles.
   - Required: rd_err 0,0,0,1 and rd_last only on the 4th beat.
4. Wrap burst:
   - Stimulus: req_addr=6, req_len=3, req_wrap=1.
   - Required: rd_data 12,14,0,2, with rd_err=0 on all beats.
5. Back-pressure:
   - Stimulus: req_addr=0, req_len=2; drop rd_ready to 0 for 2 cycles while beat 1 is presented.
   - Required: rd_data=2 held stable with rd_valid=1 during the stall.
   - Required: the accepted sequence is exactly 0,2,4, with rd_last on 4.
6. Reset mid-burst and request ignored while busy:
   - Stimulus: start req_addr=0, req_len=7. Pulse req_valid during beat 1. Assert rst_n=0 for 1 cycle at beat 2.
   - Required: req_ready=0 while busy.
   - Required: rd_valid=0 after the reset edge, with no further beats.
   - Required: a new request with req_addr=1, req_len=0 then returns 2.
